hum_ctrl: RTL and testbench
===========================

HUM_CTRL -- requirements
Module: hum_ctrl

Interface
REQ-001 SHALL have parameter MIN_ON_COUNT, default 100_000_000: minimum actuator on-time in pclk cycles (1 s at 100 MHz).
REQ-002 SHALL have parameter DEAD_COUNT, default 50_000_000: forced all-off time after any actuator turn-off.
REQ-003 SHALL have port pclk, input, 1: single clock, rising edge.
REQ-004 SHALL have port preset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port ctrl_en, input, 1: control enable.
REQ-006 SHALL have port hum_valid, input, 1: one-cycle strobe qualifying hum_data.
REQ-007 SHALL have port hum_data, input, 8: relative humidity, %RH (0-255 accepted).
REQ-008 SHALL have port hum_low_th, input, 8: humidify-on threshold, held quasi-static.
REQ-009 SHALL have port hum_high_th, input, 8: dehumidify-on threshold, held quasi-static.
REQ-010 SHALL have port hyst, input, 4: hysteresis band in %RH.
REQ-011 SHALL have port humidifier_en, output, 1: drives the humidifier and its blinker.
REQ-012 SHALL have port dehumidifier_en, output, 1: drives the dehumidifier and its blinker.
REQ-013 SHALL have port cfg_err, output, 1: set when hum_low_th >= hum_high_th.

Function
REQ-014 SHALL capture hum_data into register hum_q on each pclk edge where hum_valid=1, and SHALL set sticky flag seen=1; seen clears only on reset.
REQ-015 SHALL implement FSM states IDLE, HUMIDIFY, DEHUMIDIFY, COOLDOWN; outputs decoded from state register only (Moore).
REQ-016 SHALL drive humidifier_en=1 only in HUMIDIFY and dehumidifier_en=1 only in DEHUMIDIFY; both outputs SHALL never be 1 together.
REQ-017 SHALL drive cfg_err combinationally as (hum_low_th >= hum_high_th).
REQ-018 IDLE -> HUMIDIFY when ctrl_en=1, seen=1, cfg_err=0, and hum_q < hum_low_th.
REQ-019 IDLE -> DEHUMIDIFY when ctrl_en=1, seen=1, cfg_err=0, and hum_q > hum_high_th.
REQ-020 When IDLE holds, cfg_err=1, or ctrl_en=0, the FSM SHALL remain in IDLE.
REQ-021 SHALL clear the on-counter on entry to HUMIDIFY/DEHUMIDIFY and increment it each cycle there, saturating at MIN_ON_COUNT-1.
REQ-022 HUMIDIFY -> COOLDOWN when counter == MIN_ON_COUNT-1 and hum_q >= min(hum_low_th + hyst, 255), computed 9-bit and saturated.
REQ-023 DEHUMIDIFY -> COOLDOWN when counter == MIN_ON_COUNT-1 and hum_q <= max(hum_high_th - hyst, 0), floored at 0.
REQ-024 ctrl_en=0 or cfg_err=1 in HUMIDIFY/DEHUMIDIFY SHALL force COOLDOWN on the next edge, overriding the minimum on-time.
REQ-025 COOLDOWN SHALL last exactly DEAD_COUNT cycles (counter cleared on entry) and then go to IDLE; there is no direct HUMIDIFY<->DEHUMIDIFY transition.
REQ-026 Latency: a hum_valid strobe at edge k updates hum_q at edge k; a resulting state change occurs at edge k+1; the output changes after edge k+1.
REQ-027 hum_valid arriving in any state SHALL update hum_q; samples arriving in COOLDOWN are used on return to IDLE.

Reset
REQ-028 preset=1 SHALL immediately force state=IDLE, hum_q=0, seen=0, and counter=0, giving humidifier_en=0 and dehumidifier_en=0; cfg_err follows its inputs.
REQ-029 Reset asserted mid-HUMIDIFY/DEHUMIDIFY/COOLDOWN SHALL drop outputs asynchronously without passing through COOLDOWN.

Structure
REQ-030 The state enum (hum_state_t) and the default count constants SHALL live in the shared package hum_pkg, next to the blinker timing constants.
REQ-031 SHALL reuse the existing counter_en sub-module (COUNTER_WIDTH=$clog2(max(MIN_ON_COUNT,DEAD_COUNT))+1), with counter_clear driven on state entry; saturation is enforced by gating en.

Verification (MIN_ON_COUNT=8, DEAD_COUNT=4, low_th=40, high_th=60, hyst=3)
REQ-032 Dry cycle: ctrl_en=1, hum_valid with 35 -> humidifier_en=1 two edges later; 44 sent at on-cycle 2 -> stays on until counter=7, then 4 cycles all-off, then IDLE.
REQ-033 Hysteresis: in HUMIDIFY, hold 42 (<43) beyond 8 cycles -> stays on; 43 -> off on next edge.
REQ-034 Wet cycle and floor: 70 -> dehumidifier_en=1; 58 (>57) -> stays on; 57 -> COOLDOWN. With high_th=2 and hyst=3, exit only at hum_q=0.
REQ-035 Config error: low_th=60, high_th=60 -> cfg_err=1; hum 10 -> both outputs stay 0; in HUMIDIFY, setting the error -> COOLDOWN next edge.
REQ-036 Override/reset: ctrl_en=0 at on-cycle 1 -> COOLDOWN next edge; preset pulse mid-DEHUMIDIFY -> outputs 0 without waiting for a clock, seen=0, no re-entry until a new hum_valid.
REQ-037 Assertion, all tests: !(humidifier_en && dehumidifier_en); every on-to-other-on change is separated by >= DEAD_COUNT all-off cycles.

Source files
------------

// File: rtl/hum_pkg.sv
// Shared types and constants for the humidity controller: FSM state encoding,
// default on/dead times, blinker timing, and hysteresis threshold helpers.
package hum_pkg;

  localparam int unsigned HUM_W  = 8;
  localparam int unsigned HYST_W = 4;

  // Defaults assume a 100 MHz pclk.
  localparam int unsigned DEF_MIN_ON_COUNT = 100_000_000;
  localparam int unsigned DEF_DEAD_COUNT   = 50_000_000;

  // Actuator blinkers: 0.25 s on / 0.25 s off at 100 MHz.
  localparam int unsigned BLINK_ON_COUNT  = 25_000_000;
  localparam int unsigned BLINK_OFF_COUNT = 25_000_000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HUMIDIFY   = 2'd1,
    DEHUMIDIFY = 2'd2,
    COOLDOWN   = 2'd3
  } hum_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Humidify exit level: low threshold plus hysteresis, saturated at full scale.
  function automatic logic [HUM_W-1:0] dry_exit_th(input logic [HUM_W-1:0]  low_th,
                                                   input logic [HYST_W-1:0] hyst);
    logic [HUM_W:0] sum;
    sum = (HUM_W+1)'(low_th) + (HUM_W+1)'(hyst);
    return sum[HUM_W] ? {HUM_W{1'b1}} : sum[HUM_W-1:0];
  endfunction

  // Dehumidify exit level: high threshold minus hysteresis, floored at zero.
  function automatic logic [HUM_W-1:0] wet_exit_th(input logic [HUM_W-1:0]  high_th,
                                                   input logic [HYST_W-1:0] hyst);
    return (high_th > HUM_W'(hyst)) ? (high_th - HUM_W'(hyst)) : '0;
  endfunction

endpackage

// File: rtl/counter_en.sv
// Free-running up-counter with synchronous clear and count enable;
// clear has priority, async active-high reset.
module counter_en #(
  parameter int unsigned COUNTER_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     en_i,
  output logic [COUNTER_WIDTH-1:0] count_o
);

  logic [COUNTER_WIDTH-1:0] count_q;
  logic [COUNTER_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hum_ctrl.sv
// Humidity controller: hysteretic humidify/dehumidify FSM with a minimum
// actuator on-time and a forced all-off cooldown between any two on periods.
module hum_ctrl
  import hum_pkg::*;
#(
  parameter int unsigned MIN_ON_COUNT = DEF_MIN_ON_COUNT,
  parameter int unsigned DEAD_COUNT   = DEF_DEAD_COUNT
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              ctrl_en,
  input  logic              hum_valid,
  input  logic [HUM_W-1:0]  hum_data,
  input  logic [HUM_W-1:0]  hum_low_th,
  input  logic [HUM_W-1:0]  hum_high_th,
  input  logic [HYST_W-1:0] hyst,
  output logic              humidifier_en,
  output logic              dehumidifier_en,
  output logic              cfg_err
);

  localparam int unsigned CNT_W = $clog2(max_u(MIN_ON_COUNT, DEAD_COUNT)) + 1;
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON_COUNT - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_COUNT - 1);

  hum_state_t        state_q;
  hum_state_t        state_d;
  logic [HUM_W-1:0]  hum_q;
  logic [HUM_W-1:0]  hum_d;
  logic              seen_q;
  logic              seen_d;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_clear;
  logic              cnt_en;
  logic              run_ok;
  logic              on_done;
  logic [HUM_W-1:0]  dry_th;
  logic [HUM_W-1:0]  wet_th;

  assign cfg_err = (hum_low_th >= hum_high_th);
  assign run_ok  = ctrl_en && !cfg_err;
  assign on_done = (cnt == ON_LAST);
  assign dry_th  = dry_exit_th(hum_low_th, hyst);
  assign wet_th  = wet_exit_th(hum_high_th, hyst);

  // Latest humidity sample, accepted in every state.
  always_comb begin
    hum_d  = hum_q;
    seen_d = seen_q;
    if (hum_valid) begin
      hum_d  = hum_data;
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      hum_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      hum_q  <= hum_d;
      seen_q <= seen_d;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; losing enable or config forces cooldown regardless of on-time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (run_ok && seen_q) begin
          if (hum_q < hum_low_th) begin
            state_d = HUMIDIFY;
          end else if (hum_q > hum_high_th) begin
            state_d = DEHUMIDIFY;
          end
        end
      end
      HUMIDIFY: begin
        if (!run_ok || (on_done && (hum_q >= dry_th))) begin
          state_d = COOLDOWN;
        end
      end
      DEHUMIDIFY: begin
        if (!run_ok || (on_done && (hum_q <= wet_th))) begin
          state_d = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (cnt == DEAD_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs and counter control; the counter restarts on every state entry.
  always_comb begin
    humidifier_en   = 1'b0;
    dehumidifier_en = 1'b0;
    cnt_clear       = (state_d != state_q);
    cnt_en          = 1'b0;
    case (state_q)
      HUMIDIFY: begin
        humidifier_en = 1'b1;
        cnt_en        = !on_done;
      end
      DEHUMIDIFY: begin
        dehumidifier_en = 1'b1;
        cnt_en          = !on_done;
      end
      COOLDOWN: cnt_en = (cnt != DEAD_LAST);
      default: cnt_en = 1'b0;
    endcase
  end

  counter_en #(
    .COUNTER_WIDTH (CNT_W)
  ) u_cnt (
    .clk_i   (pclk),
    .rst_i   (preset),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .count_o (cnt)
  );

endmodule

// File: tb/tb_hum_ctrl.sv
// Scoreboard bench for hum_ctrl with short on/dead times: expected outputs are
// queued as each cycle's stimulus is driven and compared at the following negedge.
module tb_hum_ctrl;

  localparam int unsigned MIN_ON = 8;
  localparam int unsigned DEAD   = 4;

  typedef struct packed {
    logic h;
    logic d;
    logic cfg;
  } exp_t;

  logic       pclk;
  logic       preset;
  logic       ctrl_en;
  logic       hum_valid;
  logic [7:0] hum_data;
  logic [7:0] hum_low_th;
  logic [7:0] hum_high_th;
  logic [3:0] hyst;
  logic       humidifier_en;
  logic       dehumidifier_en;
  logic       cfg_err;

  exp_t        exp_q[$];
  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned last_kind;
  int unsigned off_run;
  string       phase;

  hum_ctrl #(
    .MIN_ON_COUNT (MIN_ON),
    .DEAD_COUNT   (DEAD)
  ) dut (
    .pclk            (pclk),
    .preset          (preset),
    .ctrl_en         (ctrl_en),
    .hum_valid       (hum_valid),
    .hum_data        (hum_data),
    .hum_low_th      (hum_low_th),
    .hum_high_th     (hum_high_th),
    .hyst            (hyst),
    .humidifier_en   (humidifier_en),
    .dehumidifier_en (dehumidifier_en),
    .cfg_err         (cfg_err)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Pop one expectation, compare, and track mutual exclusion and dead gaps.
  task automatic sample();
    exp_t        e;
    int unsigned kind;
    e = exp_q.pop_front();
    check_val({phase, ".humidifier_en"}, 32'(humidifier_en), 32'(e.h));
    check_val({phase, ".dehumidifier_en"}, 32'(dehumidifier_en), 32'(e.d));
    check_val({phase, ".cfg_err"}, 32'(cfg_err), 32'(e.cfg));
    check_val({phase, ".mutex"}, 32'(humidifier_en & dehumidifier_en), 32'(0));
    kind = humidifier_en ? 1 : (dehumidifier_en ? 2 : 0);
    if (kind != 0 && last_kind != 0 && kind != last_kind) begin
      check_val({phase, ".dead_gap"}, 32'(off_run >= DEAD), 32'(1));
    end
    if (kind == 0) begin
      off_run++;
    end else begin
      off_run   = 0;
      last_kind = kind;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] dat, input logic eh, input logic ed);
    exp_t e;
    hum_valid = v;
    hum_data  = dat;
    e.h   = eh;
    e.d   = ed;
    e.cfg = (hum_low_th >= hum_high_th);
    exp_q.push_back(e);
    @(negedge pclk);
    sample();
    #1;
  endtask

  task automatic idle_n(input int n, input logic eh, input logic ed);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'd0, eh, ed);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    last_kind   = 0;
    off_run     = 0;
    phase       = "reset";
    preset      = 1'b1;
    ctrl_en     = 1'b1;
    hum_valid   = 1'b0;
    hum_data    = 8'd0;
    hum_low_th  = 8'd40;
    hum_high_th = 8'd60;
    hyst        = 4'd3;
    @(negedge pclk);
    check_val("reset.humidifier_en", 32'(humidifier_en), 32'(0));
    check_val("reset.dehumidifier_en", 32'(dehumidifier_en), 32'(0));
    check_val("reset.cfg_err", 32'(cfg_err), 32'(0));
    #1 preset = 1'b0;

    // Dry cycle: on two edges after the sample, min on-time, 4-cycle cooldown.
    phase = "dry";
    step(1'b1, 8'd35, 1'b0, 1'b0);
    idle_n(2, 1'b1, 1'b0);
    step(1'b1, 8'd44, 1'b1, 1'b0);
    idle_n(5, 1'b1, 1'b0);
    idle_n(1, 1'b0, 1'b0);
    step(1'b1, 8'd70, 1'b0, 1'b0);
    idle_n(3, 1'b0, 1'b0);
    idle_n(1, 1'b0, 1'b1);

    // Wet cycle: 58 holds, 57 exits.
    phase = "wet";
    step(1'b1, 8'd58, 1'b0, 1'b1);
    idle_n(8, 1'b0, 1'b1);
    step(1'b1, 8'd57, 1'b0, 1'b1);
    idle_n(6, 1'b0, 1'b0);

    // Hysteresis: 42 holds past min on-time, 43 exits.
    phase = "hyst";
    step(1'b1, 8'd30, 1'b0, 1'b0);
    idle_n(1, 1'b1, 1'b0);
    step(1'b1, 8'd42, 1'b1, 1'b0);
    idle_n(11, 1'b1, 1'b0);
    step(1'b1, 8'd43, 1'b1, 1'b0);
    idle_n(5, 1'b0, 1'b0);

    // Floor: high_th=2, hyst=3 -> only 0 ends dehumidify.
    phase = "floor";
    hum_low_th  = 8'd0;
    hum_high_th = 8'd2;
    idle_n(1, 1'b0, 1'b1);
    step(1'b1, 8'd1, 1'b0, 1'b1);
    idle_n(10, 1'b0, 1'b1);
    step(1'b1, 8'd0, 1'b0, 1'b1);
    idle_n(5, 1'b0, 1'b0);

    // Ceiling: 250+15 saturates to 255.
    phase = "ceil";
    hum_low_th  = 8'd250;
    hum_high_th = 8'd255;
    hyst        = 4'd15;
    idle_n(1, 1'b1, 1'b0);
    step(1'b1, 8'd200, 1'b1, 1'b0);
    idle_n(9, 1'b1, 1'b0);
    step(1'b1, 8'd254, 1'b1, 1'b0);
    idle_n(2, 1'b1, 1'b0);
    step(1'b1, 8'd255, 1'b1, 1'b0);
    idle_n(5, 1'b0, 1'b0);

    // Config error blocks entry and aborts an active humidify.
    phase = "cfg";
    hyst        = 4'd3;
    hum_low_th  = 8'd60;
    hum_high_th = 8'd60;
    step(1'b1, 8'd10, 1'b0, 1'b0);
    idle_n(3, 1'b0, 1'b0);
    hum_low_th = 8'd40;
    idle_n(2, 1'b1, 1'b0);
    hum_high_th = 8'd40;
    idle_n(6, 1'b0, 1'b0);

    // Enable drop at on-cycle 1 overrides the minimum on-time.
    phase = "override";
    hum_high_th = 8'd60;
    idle_n(2, 1'b1, 1'b0);
    ctrl_en = 1'b0;
    idle_n(5, 1'b0, 1'b0);
    step(1'b1, 8'd70, 1'b0, 1'b0);
    ctrl_en = 1'b1;
    idle_n(2, 1'b0, 1'b1);

    // Async reset mid-dehumidify, no clock edge in between.
    phase = "preset";
    preset = 1'b1;
    #1;
    check_val("preset.humidifier_en", 32'(humidifier_en), 32'(0));
    check_val("preset.dehumidifier_en", 32'(dehumidifier_en), 32'(0));
    check_val("preset.cfg_err", 32'(cfg_err), 32'(0));
    #1 preset = 1'b0;
    last_kind = 0;
    off_run   = 0;

    phase = "post_reset";
    idle_n(3, 1'b0, 1'b0);
    step(1'b1, 8'd70, 1'b0, 1'b0);
    idle_n(2, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
